// File: rtl/sysctl_pkg.sv
// Shared types and helpers for the 68000 system-control block.
// Holds the DTACK state encoding, the IACK function code and the interrupt-level priority helper.
package sysctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXT  = 2'd2,
        ST_ACK  = 2'd3
    } dtack_state_t;

    localparam logic [2:0] FC_IACK = 3'b111;
    localparam int         LVL_W   = 3;
    localparam int         MAX_IRQ = 7;

    // Highest level among the pending sources; 0 when nothing is pending.
    function automatic logic [LVL_W-1:0] max_level(input logic [MAX_IRQ-1:0]       pend,
                                                   input logic [MAX_IRQ*LVL_W-1:0] levels);
        logic [LVL_W-1:0] m;
        logic [LVL_W-1:0] l;
        m = '0;
        for (int i = 0; i < MAX_IRQ; i++) begin
            l = levels[i*LVL_W +: LVL_W];
            if (pend[i] && (l > m)) m = l;
        end
        return m;
    endfunction

endpackage

// File: rtl/sysctl_irq_enc.sv
// IRQ front end: 2-FF sync + edge detect, pending latches, registered priority encoder.
// Edge to ipl_n takes 4 clk; no backpressure, the CPU acknowledges through IACK clears.
module sysctl_irq_enc
    import sysctl_pkg::*;
#(
    parameter int                       NUM_IRQ    = 2,
    parameter logic [NUM_IRQ*LVL_W-1:0] IRQ_LEVELS = {3'd5, 3'd4}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               iack_fall,
    input  logic [LVL_W-1:0]   addr_lvl,
    output logic [NUM_IRQ-1:0] irq_pend,
    output logic [LVL_W-1:0]   ipl_n
);

    logic [NUM_IRQ-1:0]       src_s1, src_s2, src_s3;
    logic [NUM_IRQ-1:0]       rise, lvl_hit, pend_nx;
    logic [MAX_IRQ-1:0]       pend_pad;
    logic [MAX_IRQ*LVL_W-1:0] lvl_pad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_s1 <= '0;
            src_s2 <= '0;
            src_s3 <= '0;
        end else begin
            src_s1 <= irq_src;
            src_s2 <= src_s1;
            src_s3 <= src_s2;
        end
    end

    always_comb begin : decode
        logic [LVL_W-1:0] lvl;
        lvl     = '0;
        rise    = '0;
        lvl_hit = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            lvl        = IRQ_LEVELS[i*LVL_W +: LVL_W];
            rise[i]    = src_s2[i] & ~src_s3[i] & (lvl != '0);
            lvl_hit[i] = iack_fall & (lvl == addr_lvl) & (lvl != '0);
        end
    end

    // Disable dominates; a new edge beats an IACK clear so no request is lost.
    assign pend_nx = irq_en & (rise | (irq_pend & ~lvl_hit));

    always_comb begin
        pend_pad                          = '0;
        pend_pad[NUM_IRQ-1:0]             = irq_pend;
        lvl_pad                           = '0;
        lvl_pad[NUM_IRQ*LVL_W-1:0]        = IRQ_LEVELS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_pend <= '0;
            ipl_n    <= '1;
        end else begin
            irq_pend <= pend_nx;
            ipl_n    <= ~max_level(pend_pad, lvl_pad);
        end
    end

endmodule

// File: rtl/m68k_sysctl.sv
// 68000 system control: IRQ encoder, DTACK wait-state FSM, watchdog reset generator.
// dtack_n is registered (ACK on the edge the FSM enters it); bus cycles stretch via wait states or ext_dtack_n.
module m68k_sysctl
    import sysctl_pkg::*;
#(
    parameter int                       NUM_IRQ     = 2,
    parameter logic [NUM_IRQ*LVL_W-1:0] IRQ_LEVELS  = {3'd5, 3'd4},
    parameter int                       WAIT_STATES = 1,
    parameter int                       WDOG_BITS   = 20,
    parameter logic [WDOG_BITS-1:0]     WDOG_LIMIT  = 20'hFFFFF,
    parameter int                       WDOG_PULSE  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               nAS,
    input  logic [2:0]         fc,
    input  logic [2:0]         addr_lvl,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               slow_cs,
    input  logic               ext_cs,
    input  logic               ext_dtack_n,
    output logic [2:0]         ipl_n,
    output logic               dtack_n,
    output logic [NUM_IRQ-1:0] irq_pend,
    input  logic               afr,
    input  logic               wdog_dis,
    output logic               wdog_rst
);

    localparam bit             HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0]     WAIT_INIT = 4'(WAIT_STATES);
    localparam int             PW        = $clog2(WDOG_PULSE + 1);
    localparam logic [PW-1:0]  PULSE_INIT = PW'(WDOG_PULSE - 1);
    localparam logic [WDOG_BITS-1:0] FIRE_AT = WDOG_LIMIT - 1'b1;

    logic         nas_q, nas_fall, iack, iack_fall;
    logic         ext_s1, ext_s2;
    dtack_state_t state, state_nx;
    logic [3:0]   wait_cnt;
    logic         wait_done, wait_load, dtack_nx;
    logic         afr_q, afr_fall;
    logic [WDOG_BITS-1:0] wdog_cnt;
    logic [PW-1:0]        pulse_cnt;

    assign nas_fall  = nas_q & ~nAS;
    assign iack      = (fc == FC_IACK);
    assign iack_fall = nas_fall & iack;
    assign afr_fall  = afr_q & ~afr;

    sysctl_irq_enc #(
        .NUM_IRQ    (NUM_IRQ),
        .IRQ_LEVELS (IRQ_LEVELS)
    ) u_irq_enc (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .irq_en    (irq_en),
        .iack_fall (iack_fall),
        .addr_lvl  (addr_lvl),
        .irq_pend  (irq_pend),
        .ipl_n     (ipl_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nas_q  <= 1'b1;
            ext_s1 <= 1'b1;
            ext_s2 <= 1'b1;
        end else begin
            nas_q  <= nAS;
            ext_s1 <= ext_dtack_n;
            ext_s2 <= ext_s1;
        end
    end

    // dtack_n comes straight from a flop so reset and state changes cannot glitch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            dtack_n <= 1'b1;
        end else begin
            state   <= state_nx;
            dtack_n <= dtack_nx;
        end
    end

    assign wait_done = (wait_cnt == 4'd0) || (clk_en && (wait_cnt == 4'd1));

    always_comb begin
        state_nx = state;
        if (nAS) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (nas_fall) begin
                    if (iack)                      state_nx = ST_ACK;
                    else if (slow_cs && HAS_WAIT)  state_nx = ST_WAIT;
                    else if (ext_cs)               state_nx = ST_EXT;
                    else                           state_nx = ST_ACK;
                end
                ST_WAIT: if (wait_done) state_nx = ext_cs ? ST_EXT : ST_ACK;
                ST_EXT:  if (!ext_s2)   state_nx = ST_ACK;
                ST_ACK:  state_nx = ST_ACK;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dtack_nx  = (state_nx != ST_ACK);
        wait_load = (state == ST_IDLE) && (state_nx == ST_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (wait_load) begin
            wait_cnt <= WAIT_INIT;
        end else if ((state == ST_WAIT) && clk_en && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // During the pulse the counter is held at 0; counting restarts once wdog_rst drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            afr_q     <= 1'b1;
            wdog_cnt  <= '0;
            pulse_cnt <= '0;
            wdog_rst  <= 1'b0;
        end else begin
            afr_q <= afr;
            if (wdog_rst) begin
                wdog_cnt <= '0;
                if (pulse_cnt == '0) wdog_rst  <= 1'b0;
                else                 pulse_cnt <= pulse_cnt - 1'b1;
            end else if (wdog_dis || afr_fall) begin
                wdog_cnt <= '0;
            end else if (clk_en) begin
                if (wdog_cnt >= FIRE_AT) begin
                    wdog_cnt  <= '0;
                    wdog_rst  <= 1'b1;
                    pulse_cnt <= PULSE_INIT;
                end else begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_m68k_sysctl.sv
// Scoreboard bench for m68k_sysctl: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_m68k_sysctl;

    localparam int S_IPL  = 0;
    localparam int S_DTK  = 1;
    localparam int S_PEND = 2;
    localparam int S_WRST = 3;

    logic       clk = 1'b0;
    logic       reset, clk_en, nAS, slow_cs, ext_cs, ext_dtack_n, afr, wdog_dis;
    logic [2:0] fc, addr_lvl, ipl_n;
    logic [1:0] irq_src, irq_en, irq_pend;
    logic       dtack_n, wdog_rst;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         q_cyc[$];
    int         q_sig[$];
    logic [7:0] q_exp[$];
    string      q_nm[$];

    m68k_sysctl #(
        .NUM_IRQ     (2),
        .IRQ_LEVELS  ({3'd5, 3'd4}),
        .WAIT_STATES (3),
        .WDOG_BITS   (20),
        .WDOG_LIMIT  (20'd100),
        .WDOG_PULSE  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .nAS         (nAS),
        .fc          (fc),
        .addr_lvl    (addr_lvl),
        .irq_src     (irq_src),
        .irq_en      (irq_en),
        .slow_cs     (slow_cs),
        .ext_cs      (ext_cs),
        .ext_dtack_n (ext_dtack_n),
        .ipl_n       (ipl_n),
        .dtack_n     (dtack_n),
        .irq_pend    (irq_pend),
        .afr         (afr),
        .wdog_dis    (wdog_dis),
        .wdog_rst    (wdog_rst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input int s);
        case (s)
            S_IPL:   return {5'b0, ipl_n};
            S_DTK:   return {7'b0, dtack_n};
            S_PEND:  return {6'b0, irq_pend};
            default: return {7'b0, wdog_rst};
        endcase
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int c, input int s, input logic [7:0] e, input string nm);
        q_cyc.push_back(c);
        q_sig.push_back(s);
        q_exp.push_back(e);
        q_nm.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            check(q_nm[0], sample(q_sig[0]), q_exp[0]);
            q_cyc.delete(0);
            q_sig.delete(0);
            q_exp.delete(0);
            q_nm.delete(0);
        end
    end

    initial begin
        int c, e;
        reset = 1'b1; clk_en = 1'b0; nAS = 1'b1; fc = 3'b101; addr_lvl = 3'd0;
        irq_src = 2'b00; irq_en = 2'b11; slow_cs = 1'b0; ext_cs = 1'b0;
        ext_dtack_n = 1'b1; afr = 1'b1; wdog_dis = 1'b1;
        tick(3);
        reset = 1'b0;
        expect_at(cyc, S_IPL, 8'h7, "rst_ipl");
        expect_at(cyc, S_DTK, 8'h1, "rst_dtack");
        expect_at(cyc, S_PEND, 8'h0, "rst_pend");
        expect_at(cyc, S_WRST, 8'h0, "rst_wdog");
        tick(2);

        // Source 0 (level 4)
        c = cyc; irq_src[0] = 1'b1;
        expect_at(c+3, S_PEND, 8'h1, "pend0_set");
        expect_at(c+3, S_IPL, 8'h7, "ipl_before");
        expect_at(c+4, S_IPL, 8'h3, "ipl_lvl4");
        tick(1); irq_src[0] = 1'b0; tick(6);

        // Source 1 (level 5) outranks source 0
        c = cyc; irq_src[1] = 1'b1;
        expect_at(c+3, S_PEND, 8'h3, "pend_both");
        expect_at(c+4, S_IPL, 8'h2, "ipl_lvl5");
        tick(1); irq_src[1] = 1'b0; tick(6);

        // IACK level 5 clears only source 1 and autovector-acks
        c = cyc; fc = 3'b111; addr_lvl = 3'd5; nAS = 1'b0;
        expect_at(c+1, S_PEND, 8'h1, "iack_clr");
        expect_at(c+1, S_DTK, 8'h0, "iack_dtack");
        expect_at(c+2, S_IPL, 8'h3, "ipl_after_iack");
        tick(3); nAS = 1'b1;
        expect_at(cyc+1, S_DTK, 8'h1, "iack_release");
        tick(3);

        // New edge and IACK clear land on the same clk: the set survives
        c = cyc; irq_src[1] = 1'b1;
        tick(1); irq_src[1] = 1'b0;
        tick(1); nAS = 1'b0;
        expect_at(c+3, S_PEND, 8'h3, "set_wins");
        expect_at(c+4, S_IPL, 8'h2, "set_wins_ipl");
        tick(3); nAS = 1'b1; tick(2);
        c = cyc; nAS = 1'b0;
        expect_at(c+1, S_PEND, 8'h1, "iack_clr2");
        tick(2); nAS = 1'b1; fc = 3'b101; tick(3);

        // Disable clears the latch and blocks new edges
        c = cyc; irq_en = 2'b10;
        expect_at(c+1, S_PEND, 8'h0, "en_clr");
        expect_at(c+2, S_IPL, 8'h7, "en_clr_ipl");
        tick(2);
        c = cyc; irq_src[0] = 1'b1;
        expect_at(c+3, S_PEND, 8'h0, "dis_edge");
        expect_at(c+5, S_PEND, 8'h0, "dis_edge_late");
        expect_at(c+5, S_IPL, 8'h7, "dis_edge_ipl");
        tick(1); irq_src[0] = 1'b0; tick(6);
        irq_en = 2'b11; tick(2);

        // Three wait states, clk_en every 4th clk
        c = cyc; slow_cs = 1'b1; clk_en = 1'b0; nAS = 1'b0;
        expect_at(c+3, S_DTK, 8'h1, "wait_start");
        expect_at(c+10, S_DTK, 8'h1, "wait_early");
        expect_at(c+11, S_DTK, 8'h0, "wait_ack");
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            clk_en = ((i % 4) == 2);
        end
        nAS = 1'b1; slow_cs = 1'b0;
        expect_at(cyc, S_DTK, 8'h0, "wait_hold");
        expect_at(cyc+1, S_DTK, 8'h1, "wait_release");
        tick(3);

        // External acknowledge through the 2-FF synchroniser
        c = cyc; clk_en = 1'b0; ext_cs = 1'b1; ext_dtack_n = 1'b1; nAS = 1'b0;
        expect_at(c+5, S_DTK, 8'h1, "ext_wait");
        tick(10);
        e = cyc; ext_dtack_n = 1'b0;
        expect_at(e+2, S_DTK, 8'h1, "ext_early");
        expect_at(e+3, S_DTK, 8'h0, "ext_ack");
        tick(4); nAS = 1'b1; ext_dtack_n = 1'b1;
        expect_at(cyc+1, S_DTK, 8'h1, "ext_release");
        tick(4);

        // Aborted external cycle never acknowledges
        c = cyc; nAS = 1'b0;
        for (int i = 1; i <= 8; i++) expect_at(c+i, S_DTK, 8'h1, "ext_abort");
        tick(3); nAS = 1'b1; ext_dtack_n = 1'b0;
        tick(6); ext_dtack_n = 1'b1; ext_cs = 1'b0; tick(3);

        // Watchdog fires on the 100th clk_en for 16 clk
        c = cyc; clk_en = 1'b1; wdog_dis = 1'b0;
        expect_at(c+99, S_WRST, 8'h0, "wd_pre");
        expect_at(c+100, S_WRST, 8'h1, "wd_fire");
        expect_at(c+115, S_WRST, 8'h1, "wd_hold");
        expect_at(c+116, S_WRST, 8'h0, "wd_end");
        tick(116);

        // Regular kicks keep it quiet
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            afr = ((i % 50) != 0);
            if ((i % 8) == 0) expect_at(cyc, S_WRST, 8'h0, "wd_afr");
        end
        afr = 1'b1;

        wdog_dis = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            tick(1);
            if ((i % 8) == 0) expect_at(cyc, S_WRST, 8'h0, "wd_dis");
        end

        // Async reset in the middle of an acknowledged cycle
        irq_src[0] = 1'b1; tick(1); irq_src[0] = 1'b0; tick(5);
        c = cyc; fc = 3'b101; nAS = 1'b0;
        expect_at(c+1, S_DTK, 8'h0, "pre_rst_dtack");
        expect_at(c+1, S_IPL, 8'h3, "pre_rst_ipl");
        tick(1);
        #5;
        reset = 1'b1;
        #1;
        check("arst_dtack", {7'b0, dtack_n}, 8'h1);
        check("arst_ipl", {5'b0, ipl_n}, 8'h7);
        check("arst_pend", {6'b0, irq_pend}, 8'h0);
        check("arst_wdog", {7'b0, wdog_rst}, 8'h0);
        nAS = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);

        if (q_cyc.size() != 0) begin
            errors += q_cyc.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", q_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
